// File: rtl/delay_scheduler.sv
// Round-robin front end that time-shares one fixed-latency external delay datapath
// among N_REQ requesters, tagging each transfer so its response returns to its origin.
module delay_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int DELAY = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*WIDTH-1:0] i_req_data,
  output logic [N_REQ-1:0]       o_req_ready,
  input  logic                   i_flush,
  output logic [WIDTH-1:0]       o_dly_d,
  input  logic [WIDTH-1:0]       i_dly_q,
  output logic [N_REQ-1:0]       o_rsp_valid,
  output logic [WIDTH-1:0]       o_rsp_data,
  output logic                   o_busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(DELAY + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant_idx;
  logic             grant;
  logic [DELAY-1:0] tag_vld;
  logic [IDX_W-1:0] tag_idx [DELAY];
  logic [CNT_W-1:0] count;
  logic             rsp_fire;

  // Grant search starts one above the last winner; reset and a same-cycle flush both suppress it.
  always_comb begin : arb
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    grant       = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    o_req_ready = '0;
    o_dly_d     = '0;
    if (!i_rst && state != DRAIN && !i_flush) begin
      for (int k = 1; k <= N_REQ; k++) begin
        cand     = (int'(ptr) + k) % N_REQ;
        cand_idx = IDX_W'(cand);
        if (!grant && i_req_valid[cand_idx]) begin
          grant     = 1'b1;
          grant_idx = cand_idx;
        end
      end
    end
    if (grant) begin
      o_req_ready[grant_idx] = 1'b1;
      o_dly_d                = i_req_data[grant_idx*WIDTH +: WIDTH];
    end
  end

  assign rsp_fire   = tag_vld[DELAY-1];
  assign o_rsp_data = i_dly_q;
  assign o_busy     = (count != '0);

  always_comb begin
    o_rsp_valid = '0;
    if (rsp_fire) o_rsp_valid[tag_idx[DELAY-1]] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tag_vld <= '0;
      for (int i = 0; i < DELAY; i++) tag_idx[i] <= '0;
    end else begin
      tag_vld[0] <= grant;
      tag_idx[0] <= grant_idx;
      for (int i = 1; i < DELAY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  // A grant and a response in the same cycle cancel, so the count holds.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count <= '0;
      ptr   <= IDX_W'(N_REQ - 1);
      state <= IDLE;
    end else begin
      state <= state_next;
      if (grant) ptr <= grant_idx;
      case ({grant, rsp_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_flush) state_next = DRAIN;
        else if (|i_req_valid) state_next = RUN;
      end
      RUN: begin
        if (i_flush) state_next = DRAIN;
        else if (!(|i_req_valid) && count == '0) state_next = IDLE;
      end
      DRAIN: begin
        if (!i_flush && count == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_delay_scheduler.sv
// Scoreboard bench for delay_scheduler: a queue-based reference predicts grants, busy
// and responses; a separate monitor pops expected responses as the DUT presents them.
module tb_delay_scheduler;
  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int DELAY = 2;

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] data;
    int               due;
  } rsp_t;

  logic                   i_clk = 1'b0;
  logic                   i_rst = 1'b1;
  logic [N_REQ-1:0]       i_req_valid = '0;
  logic [N_REQ*WIDTH-1:0] i_req_data = '0;
  logic                   i_flush = 1'b0;
  logic [N_REQ-1:0]       o_req_ready;
  logic [WIDTH-1:0]       o_dly_d;
  logic [WIDTH-1:0]       i_dly_q;
  logic [N_REQ-1:0]       o_rsp_valid;
  logic [WIDTH-1:0]       o_rsp_data;
  logic                   o_busy;

  logic [WIDTH-1:0] dly_pipe [DELAY];
  rsp_t             sb[$];
  int               due_q[$];
  int               cycle = 0;
  int               ptr_m = N_REQ - 1;
  bit               draining = 1'b0;
  int               n_checks = 0;
  int               n_pass = 0;

  always #5 i_clk = ~i_clk;

  delay_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH), .DELAY(DELAY)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .i_req_data(i_req_data),
    .o_req_ready(o_req_ready), .i_flush(i_flush), .o_dly_d(o_dly_d), .i_dly_q(i_dly_q),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_busy(o_busy)
  );

  // Stand-in for the external fixed-latency datapath.
  always @(posedge i_clk) begin
    dly_pipe[0] <= o_dly_d;
    for (int i = 1; i < DELAY; i++) dly_pipe[i] <= dly_pipe[i-1];
  end
  assign i_dly_q = dly_pipe[DELAY-1];

  always @(posedge i_clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cycle, act, exp);
  endtask

  function automatic logic [N_REQ*WIDTH-1:0] rand_data();
    logic [N_REQ*WIDTH-1:0] d;
    for (int i = 0; i < N_REQ; i++) d[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    return d;
  endfunction

  task automatic apply_stimulus(input logic [N_REQ-1:0] valid, input logic [N_REQ*WIDTH-1:0] data,
                                input logic flush);
    int               exp_idx;
    bit               exp_busy;
    logic [N_REQ-1:0] exp_ready;
    logic [WIDTH-1:0] exp_d;
    rsp_t             r;
    @(posedge i_clk);
    #1;
    i_req_valid = valid;
    i_req_data  = data;
    i_flush     = flush;
    @(negedge i_clk);
    while (due_q.size() > 0 && due_q[0] < cycle) void'(due_q.pop_front());
    exp_busy  = (due_q.size() != 0);
    exp_idx   = -1;
    exp_ready = '0;
    exp_d     = '0;
    if (!draining && !flush) begin
      for (int k = 1; k <= N_REQ; k++) begin
        if (exp_idx < 0 && valid[(ptr_m + k) % N_REQ]) exp_idx = (ptr_m + k) % N_REQ;
      end
    end
    if (exp_idx >= 0) begin
      exp_ready[exp_idx] = 1'b1;
      exp_d = data[exp_idx*WIDTH +: WIDTH];
    end
    check_output("req_ready", 32'(o_req_ready), 32'(exp_ready));
    check_output("dly_d", 32'(o_dly_d), 32'(exp_d));
    check_output("busy", 32'(o_busy), 32'(exp_busy));
    if (exp_idx >= 0) begin
      ptr_m  = exp_idx;
      r.idx  = exp_idx;
      r.data = exp_d;
      r.due  = cycle + DELAY;
      sb.push_back(r);
      due_q.push_back(cycle + DELAY);
    end
    if (flush) draining = 1'b1;
    else if (draining && !exp_busy) draining = 1'b0;
  endtask

  task automatic do_reset(input logic [N_REQ-1:0] valid);
    @(posedge i_clk);
    #1;
    i_rst       = 1'b1;
    i_req_valid = valid;
    i_req_data  = rand_data();
    i_flush     = 1'b0;
    #1;
    check_output("rst_req_ready", 32'(o_req_ready), 32'd0);
    check_output("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check_output("rst_busy", 32'(o_busy), 32'd0);
    check_output("rst_dly_d", 32'(o_dly_d), 32'd0);
    sb.delete();
    due_q.delete();
    ptr_m    = N_REQ - 1;
    draining = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst       = 1'b0;
    i_req_valid = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus('0, rand_data(), 1'b0);
  endtask

  // Monitor: every cycle the DUT's response strobe must match the oldest due entry (or be quiet).
  always @(negedge i_clk) begin : monitor
    logic [N_REQ-1:0] exp_v;
    if (!i_rst) begin
      while (sb.size() > 0 && sb[0].due < cycle) begin
        check_output("rsp_missed_due", 32'(cycle), 32'(sb[0].due));
        void'(sb.pop_front());
      end
      exp_v = '0;
      if (sb.size() > 0 && sb[0].due == cycle) begin
        exp_v[sb[0].idx] = 1'b1;
        check_output("rsp_valid", 32'(o_rsp_valid), 32'(exp_v));
        check_output("rsp_data", 32'(o_rsp_data), 32'(sb[0].data));
        void'(sb.pop_front());
      end else begin
        check_output("rsp_idle", 32'(o_rsp_valid), 32'd0);
      end
    end
  end

  initial begin
    logic [N_REQ*WIDTH-1:0] d;
    do_reset('1);

    d = rand_data();
    d[2*WIDTH +: WIDTH] = 8'h5A;
    apply_stimulus(4'b0100, d, 1'b0);
    idle(5);

    repeat (8) apply_stimulus(4'b1111, rand_data(), 1'b0);
    idle(4);

    for (int i = 0; i < 10; i++) apply_stimulus(4'b0011, rand_data(), i == 3);
    idle(4);

    repeat (2) apply_stimulus(4'b1111, rand_data(), 1'b0);
    do_reset('1);
    idle(DELAY + 2);

    repeat (2) apply_stimulus(4'b1000, rand_data(), 1'b0);
    repeat (2) apply_stimulus(4'b0001, rand_data(), 1'b0);
    idle(3);

    repeat (6) apply_stimulus(4'b1111, rand_data(), 1'b0);
    idle(4);

    repeat (400) apply_stimulus(N_REQ'($urandom), rand_data(), $urandom_range(0, 15) == 0);
    idle(DELAY + 3);
    check_output("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/delay_scheduler.md
DELAY_SCHEDULER -- requirements
Module: delay_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing one delay datapath (2..8).
REQ-002 Parameter WIDTH, default 8, SHALL set the data width of each request and response.
REQ-003 Parameter DELAY, default 2, SHALL set the fixed latency in cycles of the external shared delay datapath (1..8).
REQ-004 i_clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 i_rst  input  1  reset; asynchronous, active-high.
REQ-006 i_req_valid  input  N_REQ  per-requester request valid.
REQ-007 i_req_data  input  N_REQ*WIDTH  request payloads; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-008 o_req_ready  output  N_REQ  one-hot grant; a request transfers when valid and ready are both high.
REQ-009 i_flush  input  1  drain request: stop granting until the datapath is empty.
REQ-010 o_dly_d  output  WIDTH  data driven into the shared delay datapath.
REQ-011 i_dly_q  input  WIDTH  data returned from the shared delay datapath, DELAY cycles after o_dly_d.
REQ-012 o_rsp_valid  output  N_REQ  one-hot response strobe identifying the originating requester.
REQ-013 o_rsp_data  output  WIDTH  response data; equals i_dly_q.
REQ-014 o_busy  output  1  high while any transfer is in flight.

Function
REQ-015 Arbitration SHALL be round-robin: the search starts at the index one above the last granted requester, wrapping modulo N_REQ.
REQ-016 The pointer SHALL advance only on an accepted transfer.
REQ-017 o_req_ready SHALL be combinational from i_req_valid, the pointer and the FSM state.
REQ-018 o_req_ready SHALL have at most one bit high, and only for a requester whose valid is high.
REQ-019 o_dly_d SHALL equal the granted requester's data, or zero when no grant is made.
REQ-020 A tag pipeline DELAY stages deep SHALL carry {valid, index} for each grant in lockstep with the datapath.
REQ-021 o_rsp_valid SHALL be the one-hot decode of the last tag stage when that stage is valid, otherwise zero.
REQ-022 A response SHALL therefore appear exactly DELAY cycles after its accepting edge.
REQ-023 An in-flight counter of width clog2(DELAY+1)+1 SHALL increment on each grant and decrement on each response; on a simultaneous grant and response it SHALL hold.
REQ-024 o_busy SHALL equal (counter != 0).
REQ-025 FSM states: IDLE, RUN, DRAIN.
REQ-026 IDLE -> RUN on any i_req_valid while i_flush is low.
REQ-027 RUN -> IDLE when there is no valid request and the counter is zero.
REQ-028 RUN or IDLE -> DRAIN when i_flush is high.
REQ-029 DRAIN -> IDLE when the counter is zero and i_flush is low; DRAIN SHALL hold while i_flush stays high.
REQ-030 No grant SHALL be issued in DRAIN; in-flight responses SHALL still be delivered.
REQ-031 Grants SHALL be permitted in IDLE and RUN, so the first request in IDLE is granted in its first cycle.
REQ-032 If i_flush rises in the same cycle as a valid request, the request SHALL NOT be granted.
REQ-033 Sustained throughput SHALL be one transfer per cycle; there is no bubble between consecutive grants.

Reset
REQ-034 While i_rst is high, the following SHALL be forced immediately, without waiting for a clock: FSM = IDLE, round-robin pointer = N_REQ-1 so requester 0 has first priority, all tag stages invalid, counter = 0.
REQ-035 During reset, o_req_ready = 0, o_rsp_valid = 0, o_busy = 0 and o_dly_d = 0.
REQ-036 Tags in flight when reset asserts mid-operation SHALL be discarded; no o_rsp_valid SHALL occur for them after reset is released.
REQ-037 The first edge after reset deasserts SHALL be able to grant.

Verification
REQ-038 Single request, defaults: requester 2 holds valid with data 0x5A. Required: o_req_ready = 4'b0100 that cycle; o_rsp_valid = 4'b0100 and o_rsp_data = 0x5A two cycles later; o_busy high for exactly 2 cycles.
REQ-039 Fairness: all four valids held for 8 cycles after reset. Required grant order 0,1,2,3,0,1,2,3; each requester receives exactly 2 responses.
REQ-040 Flush mid-stream: requesters 0 and 1 held valid, i_flush pulsed high for 1 cycle at cycle 3. Required: no grant from cycle 3 onward until the counter reaches 0; the 2 in-flight responses are delivered; the FSM returns to IDLE and then to RUN.
REQ-041 Reset mid-operation: i_rst asserted while the counter = 2. Required: o_rsp_valid and o_busy go to 0 immediately and stay 0 through DELAY cycles after release with no requests.
REQ-042 Counter hold: back-to-back grants for 6 cycles with DELAY = 2. Required: the counter reads 1, 2, 2, 2, 2, 2 and then drains 1, 0 after the requests stop.
REQ-043 Pointer wrap: only requester 3 valid, then only requester 0 valid. Required: requester 0 is granted immediately with no idle cycle.
